// File: rtl/idelay_tap_sweep_if.sv
// Native register-port bundle between the tap sweeper (master) and the IDELAY core (slave).
interface idelay_tap_sweep_if #(
  parameter int unsigned NATIVE_ADDR_WDITH = 2,
  parameter int unsigned NATIVE_DATA_WIDTH = 9
);
  logic                         NATIVE_EN;
  logic                         NATIVE_WR;
  logic [NATIVE_ADDR_WDITH-1:0] NATIVE_ADDR;
  logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_IN;
  logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_OUT;
  logic                         NATIVE_READY;

  modport master (
    output NATIVE_EN, NATIVE_WR, NATIVE_ADDR, NATIVE_DATA_IN,
    input  NATIVE_DATA_OUT, NATIVE_READY
  );

  modport slave (
    input  NATIVE_EN, NATIVE_WR, NATIVE_ADDR, NATIVE_DATA_IN,
    output NATIVE_DATA_OUT, NATIVE_READY
  );
endinterface

// File: rtl/idelay_tap_sweep.sv
// Automatic IDELAY tap sweep: write tap, settle, majority-sample sig_in, stop at first level flip.
// Optional tap readback after each write is enabled by defining SWEEP_READBACK_EN.
module idelay_tap_sweep #(
  parameter int unsigned NATIVE_ADDR_WDITH = 2,
  parameter int unsigned NATIVE_DATA_WIDTH = 9,
  parameter int unsigned SETTLE_CYCLES     = 16,
  parameter int unsigned SAMPLE_COUNT      = 64,
  parameter int unsigned TIMEOUT_CYCLES    = 255
) (
  input  logic                            NATIVE_CLK,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [NATIVE_ADDR_WDITH-1:0]    elem_sel,
  input  logic [NATIVE_DATA_WIDTH-1:0]    tap_start,
  input  logic [NATIVE_DATA_WIDTH-1:0]    tap_stop,
  input  logic [NATIVE_DATA_WIDTH-1:0]    tap_step,
  input  logic                            sig_in,
  output logic                            busy,
  output logic                            done,
  output logic                            edge_found,
  output logic [NATIVE_DATA_WIDTH-1:0]    edge_tap,
  output logic [$clog2(SAMPLE_COUNT):0]   last_ones,
  output logic                            err_timeout,
`ifdef SWEEP_READBACK_EN
  output logic                            err_readback,
`endif
  idelay_tap_sweep_if.master              native
);

  localparam int unsigned DW     = NATIVE_DATA_WIDTH;
  localparam int unsigned AW     = NATIVE_ADDR_WDITH;
  localparam int unsigned OnesW  = $clog2(SAMPLE_COUNT) + 1;
  localparam int unsigned CntMax0 = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES
                                                                     : SETTLE_CYCLES;
  localparam int unsigned CntMax = (CntMax0 > SAMPLE_COUNT) ? CntMax0 : SAMPLE_COUNT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0]  ToLast     = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0]  SampleLast = CntW'(SAMPLE_COUNT - 1);
  localparam logic [OnesW-1:0] HalfCount  = OnesW'(SAMPLE_COUNT / 2);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
`ifdef SWEEP_READBACK_EN
    StRdback,
`endif
    StSettle,
    StSample,
    StEval,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     elem_q, elem_d;
  logic [DW-1:0]     stop_q, stop_d;
  logic [DW-1:0]     step_q, step_d;
  logic [DW-1:0]     cur_tap_q, cur_tap_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OnesW-1:0]  ones_q, ones_d;
  logic              ref_valid_q, ref_valid_d;
  logic              ref_level_q, ref_level_d;
  logic              edge_found_q, edge_found_d;
  logic [DW-1:0]     edge_tap_q, edge_tap_d;
  logic              err_to_q, err_to_d;
  logic              err_rb_q, err_rb_d;
  logic [1:0]        sync_q;
  logic [DW:0]       next_tap;
  logic              level;

  always_ff @(posedge NATIVE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers and the sig_in synchronizer share the FSM's async reset.
  always_ff @(posedge NATIVE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      elem_q       <= '0;
      stop_q       <= '0;
      step_q       <= '0;
      cur_tap_q    <= '0;
      cnt_q        <= '0;
      ones_q       <= '0;
      ref_valid_q  <= 1'b0;
      ref_level_q  <= 1'b0;
      edge_found_q <= 1'b0;
      edge_tap_q   <= '0;
      err_to_q     <= 1'b0;
      err_rb_q     <= 1'b0;
      sync_q       <= '0;
    end else begin
      elem_q       <= elem_d;
      stop_q       <= stop_d;
      step_q       <= step_d;
      cur_tap_q    <= cur_tap_d;
      cnt_q        <= cnt_d;
      ones_q       <= ones_d;
      ref_valid_q  <= ref_valid_d;
      ref_level_q  <= ref_level_d;
      edge_found_q <= edge_found_d;
      edge_tap_q   <= edge_tap_d;
      err_to_q     <= err_to_d;
      err_rb_q     <= err_rb_d;
      sync_q       <= {sync_q[0], sig_in};
    end
  end

  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    stop_d       = stop_q;
    step_d       = step_q;
    cur_tap_d    = cur_tap_q;
    cnt_d        = cnt_q;
    ones_d       = ones_q;
    ref_valid_d  = ref_valid_q;
    ref_level_d  = ref_level_q;
    edge_found_d = edge_found_q;
    edge_tap_d   = edge_tap_q;
    err_to_d     = err_to_q;
    err_rb_d     = err_rb_q;
    // One extra bit so a wrap past the tap range compares as larger than any stop.
    next_tap     = {1'b0, cur_tap_q} + {1'b0, step_q};
    level        = (ones_q >= HalfCount);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          elem_d       = elem_sel;
          stop_d       = tap_stop;
          step_d       = (tap_step == '0) ? DW'(1) : tap_step;
          cur_tap_d    = tap_start;
          cnt_d        = '0;
          edge_found_d = 1'b0;
          err_to_d     = 1'b0;
          err_rb_d     = 1'b0;
          ref_valid_d  = 1'b0;
          state_d      = (tap_start > tap_stop) ? StDone : StWrite;
        end
      end
      StWrite: begin
        if (native.NATIVE_READY) begin
          cnt_d   = '0;
`ifdef SWEEP_READBACK_EN
          state_d = StRdback;
`else
          state_d = StSettle;
`endif
        end else if (cnt_q == ToLast) begin
          err_to_d = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef SWEEP_READBACK_EN
      StRdback: begin
        if (native.NATIVE_READY) begin
          cnt_d = '0;
          if (native.NATIVE_DATA_OUT != cur_tap_q) begin
            err_rb_d = 1'b1;
            state_d  = StDone;
          end else begin
            state_d = StSettle;
          end
        end else if (cnt_q == ToLast) begin
          err_to_d = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          ones_d  = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSample: begin
        if (sync_q[1]) begin
          ones_d = ones_q + OnesW'(1);
        end
        if (cnt_q == SampleLast) begin
          cnt_d   = '0;
          state_d = StEval;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StEval: begin
        if (ref_valid_q && (level != ref_level_q)) begin
          edge_found_d = 1'b1;
          edge_tap_d   = cur_tap_q;
          state_d      = StDone;
        end else begin
          if (!ref_valid_q) begin
            ref_valid_d = 1'b1;
            ref_level_d = level;
          end
          if (next_tap > {1'b0, stop_q}) begin
            state_d = StDone;
          end else begin
            cur_tap_d = next_tap[DW-1:0];
            cnt_d     = '0;
            state_d   = StWrite;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    native.NATIVE_EN      = 1'b0;
    native.NATIVE_WR      = 1'b0;
    native.NATIVE_ADDR    = elem_q;
    native.NATIVE_DATA_IN = cur_tap_q;
    busy                  = (state_q != StIdle);
    done                  = (state_q == StDone);
    if (state_q == StWrite) begin
      native.NATIVE_EN = 1'b1;
      native.NATIVE_WR = 1'b1;
    end
`ifdef SWEEP_READBACK_EN
    if (state_q == StRdback) begin
      native.NATIVE_EN = 1'b1;
    end
`endif
  end

  assign edge_found  = edge_found_q;
  assign edge_tap    = edge_tap_q;
  assign last_ones   = ones_q;
  assign err_timeout = err_to_q;
`ifdef SWEEP_READBACK_EN
  assign err_readback = err_rb_q;
`endif

endmodule

// File: tb/tb_idelay_tap_sweep.sv
// Directed bench for idelay_tap_sweep: write scoreboard plus immediate-assertion checks.
module tb_idelay_tap_sweep;
  localparam int unsigned AW  = 2;
  localparam int unsigned DW  = 9;
  localparam int unsigned SET = 16;
  localparam int unsigned SMP = 64;
  localparam int unsigned TO  = 255;
`ifdef SWEEP_READBACK_EN
  localparam int unsigned TapCyc = SET + SMP + 3;
`else
  localparam int unsigned TapCyc = SET + SMP + 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start = 1'b0;
  logic [AW-1:0] elem_sel = '0;
  logic [DW-1:0] tap_start = '0;
  logic [DW-1:0] tap_stop = '0;
  logic [DW-1:0] tap_step = '0;
  logic          sig_in;
  logic          busy, done, edge_found, err_timeout;
  logic [DW-1:0] edge_tap;
  logic [6:0]    last_ones;
`ifdef SWEEP_READBACK_EN
  logic          err_readback;
`endif

  logic          ready_r = 1'b1;
  logic          rb_corrupt = 1'b0;
  logic [9:0]    edge_thr = '0;
  int            errors = 0;
  int            checks = 0;
  int            en_cnt = 0;
  int            n;
  logic [AW+DW-1:0] exp_q[$];

  idelay_tap_sweep_if #(.NATIVE_ADDR_WDITH(AW), .NATIVE_DATA_WIDTH(DW)) nif ();

  // Core model: READY under bench control, readback optionally corrupted, and
  // sig_in levels flip once the written tap reaches edge_thr.
  assign nif.NATIVE_READY    = ready_r;
  assign nif.NATIVE_DATA_OUT = rb_corrupt ? (nif.NATIVE_DATA_IN ^ 9'd1) : nif.NATIVE_DATA_IN;
  assign sig_in              = ({1'b0, nif.NATIVE_DATA_IN} >= edge_thr);

  idelay_tap_sweep dut (
    .NATIVE_CLK  (clk),
    .rst_n       (rst_n),
    .start       (start),
    .elem_sel    (elem_sel),
    .tap_start   (tap_start),
    .tap_stop    (tap_stop),
    .tap_step    (tap_step),
    .sig_in      (sig_in),
    .busy        (busy),
    .done        (done),
    .edge_found  (edge_found),
    .edge_tap    (edge_tap),
    .last_ones   (last_ones),
    .err_timeout (err_timeout),
`ifdef SWEEP_READBACK_EN
    .err_readback(err_readback),
`endif
    .native      (nif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every accepted write is popped and compared.
  always @(negedge clk) begin
    if (nif.NATIVE_EN) en_cnt++;
    if (nif.NATIVE_EN && nif.NATIVE_WR && nif.NATIVE_READY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(nif.NATIVE_DATA_IN), 32'hFFFF_FFFF);
      end else begin
        check("write_addr_data", 32'({nif.NATIVE_ADDR, nif.NATIVE_DATA_IN}),
              32'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_writes(input logic [AW-1:0] e, input int first, input int last,
                             input int step);
    for (int t = first; t <= last; t += step) exp_q.push_back({e, DW'(t)});
  endtask

  task automatic do_start(input logic [AW-1:0] e, input logic [DW-1:0] s0,
                          input logic [DW-1:0] s1, input logic [DW-1:0] st);
    @(negedge clk);
    elem_sel  = e;
    tap_start = s0;
    tap_stop  = s1;
    tap_step  = st;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) check("done_wait_expired", 32'(done), 1);
  endtask

  task automatic check_pulse_end();
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("busy_after_done", 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #22;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_en", 32'(nif.NATIVE_EN), 0);
    check("rst_wr", 32'(nif.NATIVE_WR), 0);
    check("rst_addr", 32'(nif.NATIVE_ADDR), 0);
    check("rst_data_in", 32'(nif.NATIVE_DATA_IN), 0);
    check("rst_edge_found", 32'(edge_found), 0);
    check("rst_edge_tap", 32'(edge_tap), 0);
    check("rst_last_ones", 32'(last_ones), 0);
    check("rst_err_timeout", 32'(err_timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Edge at tap 10, taps 0..20 step 1.
    edge_thr = 10'd10;
    push_writes(2'd2, 0, 10, 1);
    do_start(2'd2, 9'd0, 9'd20, 9'd1);
    check("t1_busy", 32'(busy), 1);
    wait_done(20 * TapCyc, n);
    check("t1_cycles", n, 11 * TapCyc);
    check("t1_edge_found", 32'(edge_found), 1);
    check("t1_edge_tap", 32'(edge_tap), 10);
    check("t1_last_ones", 32'(last_ones), 64);
    check("t1_err_timeout", 32'(err_timeout), 0);
    check("t1_all_writes", exp_q.size(), 0);
`ifdef SWEEP_READBACK_EN
    check("t1_err_readback", 32'(err_readback), 0);
`endif
    check_pulse_end();
    check("t1_result_hold", 32'(edge_tap), 10);

    // Constant level, 5..11 step 3.
    edge_thr = 10'd0;
    push_writes(2'd1, 5, 11, 3);
    do_start(2'd1, 9'd5, 9'd11, 9'd3);
    wait_done(10 * TapCyc, n);
    check("t2_cycles", n, 3 * TapCyc);
    check("t2_edge_found", 32'(edge_found), 0);
    check("t2_last_ones", 32'(last_ones), 64);
    check("t2_all_writes", exp_q.size(), 0);
    check_pulse_end();

    // Step 0 behaves as step 1; edge at tap 3.
    edge_thr = 10'd3;
    push_writes(2'd3, 2, 3, 1);
    do_start(2'd3, 9'd2, 9'd3, 9'd0);
    wait_done(10 * TapCyc, n);
    check("t3_cycles", n, 2 * TapCyc);
    check("t3_edge_found", 32'(edge_found), 1);
    check("t3_edge_tap", 32'(edge_tap), 3);
    check("t3_all_writes", exp_q.size(), 0);

    // READY held low: timeout.
    ready_r = 1'b0;
    en_cnt  = 0;
    do_start(2'd0, 9'd0, 9'd5, 9'd1);
    wait_done(TO + 20, n);
    check("t4_cycles", n, TO);
    check("t4_en_cycles", en_cnt, TO);
    check("t4_err_timeout", 32'(err_timeout), 1);
    check("t4_en_low", 32'(nif.NATIVE_EN), 0);
    check("t4_edge_found", 32'(edge_found), 0);
    check("t4_no_sample", 32'(last_ones), 64);
    check_pulse_end();

    // Reversed range: immediate done, no transactions.
    ready_r = 1'b1;
    en_cnt  = 0;
    do_start(2'd0, 9'd7, 9'd3, 9'd1);
    wait_done(10, n);
    check("t5_cycles", n, 0);
    check("t5_err_timeout_clr", 32'(err_timeout), 0);
    check_pulse_end();
    check("t5_no_en", en_cnt, 0);

    // Overflow past the 9-bit range ends after a single tap.
    edge_thr = 10'd0;
    push_writes(2'd2, 300, 300, 1);
    do_start(2'd2, 9'd300, 9'd511, 9'd256);
    wait_done(4 * TapCyc, n);
    check("t6_cycles", n, TapCyc);
    check("t6_edge_found", 32'(edge_found), 0);
    check("t6_all_writes", exp_q.size(), 0);

    // Asynchronous reset in the middle of a write.
    ready_r = 1'b0;
    do_start(2'd1, 9'd0, 9'd9, 9'd1);
    repeat (3) @(negedge clk);
    check("t7_en_before", 32'(nif.NATIVE_EN), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_en_async", 32'(nif.NATIVE_EN), 0);
    check("t7_busy_async", 32'(busy), 0);
    check("t7_done_async", 32'(done), 0);
    check("t7_last_ones_clr", 32'(last_ones), 0);
    @(negedge clk);
    rst_n   = 1'b1;
    ready_r = 1'b1;
    push_writes(2'd1, 0, 1, 1);
    do_start(2'd1, 9'd0, 9'd1, 9'd1);
    wait_done(4 * TapCyc, n);
    check("t7_cycles", n, 2 * TapCyc);
    check("t7_all_writes", exp_q.size(), 0);

`ifdef SWEEP_READBACK_EN
    // Core returns a corrupted tap on readback.
    rb_corrupt = 1'b1;
    push_writes(2'd0, 4, 4, 1);
    do_start(2'd0, 9'd4, 9'd8, 9'd1);
    wait_done(4 * TapCyc, n);
    check("t8_cycles", n, 2);
    check("t8_err_readback", 32'(err_readback), 1);
    check("t8_edge_found", 32'(edge_found), 0);
    check("t8_all_writes", exp_q.size(), 0);
    rb_corrupt = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idelay_tap_sweep.md
Name: idelay_tap_sweep

Overview:
Native-bus master that sits upstream of the IDELAY core's native register port and performs an automatic tap sweep on one delay element. For each tap it writes the tap value and waits for the delay to settle. It then samples the delayed signal returned from the core and stops at the first tap where the majority-sampled level flips. The software-driven AXI path and this sweeper are muxed onto the core's native port outside this block.

Parameters:
NATIVE_ADDR_WDITH, 2, native address width; address = delay element index
NATIVE_DATA_WIDTH, 9, tap value width
SETTLE_CYCLES, 16, idle cycles after each accepted write before sampling (>=1)
SAMPLE_COUNT, 64, samples per tap; must be even, >=2
TIMEOUT_CYCLES, 255, max cycles waiting for NATIVE_READY per transaction

Ports:
NATIVE_CLK  in  1  single clock (same clock as the core's native port)
rst_n  in  1  asynchronous active-low reset
start  in  1  sweep request; sampled only in IDLE
elem_sel  in  NATIVE_ADDR_WDITH  element to sweep
tap_start  in  NATIVE_DATA_WIDTH  first tap
tap_stop  in  NATIVE_DATA_WIDTH  last tap, inclusive
tap_step  in  NATIVE_DATA_WIDTH  increment; 0 treated as 1
sig_in  in  1  delayed signal from the core's signal_out; asynchronous to NATIVE_CLK
busy  out  1  high from the cycle after start is accepted through DONE
done  out  1  one-cycle completion pulse
edge_found  out  1  a level flip was detected
edge_tap  out  NATIVE_DATA_WIDTH  first tap whose level differs from tap_start's level
last_ones  out  log2(SAMPLE_COUNT)+1  ones count of the last sampled tap
err_timeout  out  1  READY not seen within TIMEOUT_CYCLES
NATIVE_EN  out  1  transaction request
NATIVE_WR  out  1  1 = write
NATIVE_ADDR  out  NATIVE_ADDR_WDITH  = latched elem_sel
NATIVE_DATA_IN  out  NATIVE_DATA_WIDTH  tap value written to the core
NATIVE_DATA_OUT  in  NATIVE_DATA_WIDTH  read data from the core
NATIVE_READY  in  1  transaction accept/complete

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. busy, done, edge_found, err_timeout, NATIVE_EN and NATIVE_WR = 0. edge_tap, last_ones, NATIVE_ADDR and NATIVE_DATA_IN = 0. The sig_in synchronizer is cleared. Reset mid-transaction drops NATIVE_EN immediately.
- sig_in passes through a 2-flop synchronizer; only the second flop's output is used.
- States: IDLE, WRITE, SETTLE, SAMPLE, EVAL, DONE (plus RDBACK with the option below).
- IDLE, start=1:
  - Latch elem_sel, tap_start, tap_stop and step (0->1).
  - Clear edge_found, err_timeout and the reference-valid flag.
  - If tap_start > tap_stop, go DONE with edge_found=0 and issue no writes; otherwise cur_tap=tap_start and go WRITE.
  - start while busy is ignored.
- WRITE:
  - Drive NATIVE_EN=1, NATIVE_WR=1, NATIVE_ADDR=elem, NATIVE_DATA_IN=cur_tap; all stay stable until NATIVE_READY=1 is sampled.
  - On the READY cycle go SETTLE; EN deasserts the next cycle, giving one transaction per write.
  - A timeout counter runs from 0. If it reaches TIMEOUT_CYCLES without READY: err_timeout=1, EN drops, go DONE.
- SETTLE: exactly SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE: exactly SAMPLE_COUNT cycles; count cycles where the synced sig=1 into last_ones.
- EVAL (1 cycle):
  - level = (last_ones >= SAMPLE_COUNT/2).
  - If no reference exists, store level as the reference.
  - Else if level != reference: edge_found=1, edge_tap=cur_tap, go DONE.
  - Otherwise next = cur_tap + step, computed NATIVE_DATA_WIDTH+1 bits wide. If next > tap_stop or overflows, go DONE with edge_found=0; else cur_tap=next, go WRITE.
- DONE: done=1 for one cycle, busy=0 on the following cycle, return to IDLE. Results hold until the next accepted start.
- Tap with READY tied high costs 1 (WRITE) + SETTLE_CYCLES + SAMPLE_COUNT + 1 (EVAL) cycles.
- NATIVE_EN never asserts outside WRITE/RDBACK.

Optional Feature:
Macro SWEEP_READBACK_EN.
- Defined:
  - After each accepted write, enter RDBACK: NATIVE_EN=1, NATIVE_WR=0, same address, held until READY under the same timeout rule.
  - On READY, compare NATIVE_DATA_OUT against cur_tap. On mismatch set err_readback=1 (extra output, reset 0, cleared on start) and go DONE; otherwise go SETTLE.
  - Adds the RDBACK handshake time to each tap.
- Undefined: no RDBACK state and no err_readback port; WRITE goes directly to SETTLE.

Test Plan:
- READY tied high; sig_in=0 for taps 0-9 and 1 from tap 10; start=0, stop=20, step=1 -> 11 writes with DATA_IN 0..10, edge_found=1, edge_tap=10, one done pulse.
- sig_in constant 1; start=5, stop=11, step=3 -> writes 5, 8, 11; edge_found=0; done asserted 3*(SETTLE_CYCLES+SAMPLE_COUNT+2) cycles after start.
- READY held low -> EN high for TIMEOUT_CYCLES cycles, then err_timeout=1, EN=0, done pulse, no SETTLE.
- tap_start=7, tap_stop=3 -> done the cycle after IDLE exit, no NATIVE_EN ever; tap_stop=511, step=256 from 300 -> single tap, overflow terminates the sweep.
- rst_n low during WRITE with EN=1 -> EN, busy and done drop asynchronously; after release, start is accepted normally.
- SWEEP_READBACK_EN defined; core returns DATA_OUT=tap^1 -> err_readback=1 after the first tap, done pulse, edge_found=0.
